register_load_arbiter: RTL and testbench

- Shares one N-bit loadable storage register between NREQ requesters.
- Each requester raises a request with its data word. The arbiter grants round-robin, loads the granted word into the register, then holds it stable for a programmable number of cycles before the next grant.
- Sits in front of the register-with-load datapath and is the only source of its load strobe.

---
 rtl/register_load_arbiter_pkg.sv | 19 +
 rtl/register_load_arbiter_rr_pick.sv | 38 +++
 rtl/register_load_arbiter.sv | 102 ++++++++++
 tb/tb_register_load_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_load_arbiter_pkg.sv
// Shared definitions for the register load arbiter: FSM encoding and width helper.
package register_load_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/register_load_arbiter_rr_pick.sv
// Round-robin pick: rotate req so the pointer sits at bit 0, take the lowest set bit,
// then rotate the one-hot result back into requester order.
module register_load_arbiter_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] pick,
    output logic [PW-1:0]   index,
    output logic            any
);

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] pick_rot;
    logic            found;

    always_comb begin
        rot      = NREQ'({req, req} >> pointer);
        pick_rot = '0;
        found    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j] && !found) begin
                pick_rot[j] = 1'b1;
                found       = 1'b1;
            end
        end
        pick  = NREQ'(({pick_rot, pick_rot} << pointer) >> NREQ);
        index = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                index = PW'(k);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/register_load_arbiter.sv
// Round-robin arbiter owning the load strobe of a shared N-bit register.
// state | meaning
// IDLE  | wait for any request, pick next requester round-robin
// LOAD  | one-cycle grant; capture data unless the requester withdrew
// HOLD  | keep Q stable for HOLD_CYCLES cycles, requests ignored
module register_load_arbiter
    import register_load_arbiter_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int N           = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*N-1:0]        data_in,
    output logic [NREQ-1:0]          grant,
    output logic                     load,
    output logic [N-1:0]             Q,
    output logic [clog2(NREQ)-1:0]   owner,
    output logic                     valid
);

    localparam int PW = clog2(NREQ);

    state_t          state;
    logic [PW-1:0]   pointer;
    logic [PW-1:0]   sel;
    logic [3:0]      hold_cnt;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   pick_index;
    logic            pick_any;

    register_load_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (req),
        .pointer (pointer),
        .pick    (pick),
        .index   (pick_index),
        .any     (pick_any)
    );

    assign load = |grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            Q        <= '0;
            owner    <= '0;
            valid    <= 1'b0;
            pointer  <= '0;
            sel      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        sel   <= pick_index;
                        state <= LOAD;
                    end else begin
                        grant <= '0;
                    end
                end
                LOAD: begin
                    grant <= '0;
                    if (req[sel]) begin
                        Q       <= data_in[int'(sel)*N +: N];
                        owner   <= sel;
                        valid   <= 1'b1;
                        pointer <= (sel == PW'(NREQ-1)) ? '0 : sel + PW'(1);
                        if (HOLD_CYCLES > 0) begin
                            hold_cnt <= 4'(HOLD_CYCLES - 1);
                            state    <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        // withdrawn request: nothing captured, pointer kept
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    grant <= '0;
                    if (hold_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Scoreboard bench for register_load_arbiter with NREQ=4, N=8, HOLD_CYCLES=2.
module tb_register_load_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic        load;
    logic [7:0]  Q;
    logic [1:0]  owner;
    logic        valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] o;
    } exp_t;
    exp_t sb[$];

    register_load_arbiter #(.NREQ(4), .N(8), .HOLD_CYCLES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .load    (load),
        .Q       (Q),
        .owner   (owner),
        .valid   (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_load(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (load !== 1'b1 && n < 12);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (Q !== 8'h00 || valid !== 1'b0 || owner !== 2'd0 || grant !== 4'b0 || load !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle: Q=%h valid=%b owner=%0d grant=%b load=%b, expected all zero",
                         Q, valid, owner, grant, load);
            end
        end
    endtask

    task automatic test_single();
        exp_t e; int n; int gc[2];
        data_in = '0; data_in[23:16] = 8'hA5; req = 4'b0100;
        sb.push_back('{g:4'b0100, d:8'hA5, o:2'd2});
        sb.push_back('{g:4'b0100, d:8'hA5, o:2'd2});
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            wait_load(n);
            gc[k] = cyc;
            checks++;
            if (grant !== e.g || (k == 0 && n != 1)) begin
                failures++;
                $display("FAIL single_grant[%0d]: grant=%b after %0d cycles, expected %b after 1", k, grant, n, e.g);
            end
            @(negedge clk);
            checks++;
            if (Q !== e.d || owner !== e.o || valid !== 1'b1) begin
                failures++;
                $display("FAIL single_load[%0d]: Q=%h owner=%0d valid=%b, expected Q=%h owner=%0d valid=1",
                         k, Q, owner, valid, e.d, e.o);
            end
        end
        checks++;
        if (gc[1] - gc[0] != 4) begin
            failures++;
            $display("FAIL single_spacing: grants %0d cycles apart, expected 4", gc[1] - gc[0]);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_all_request();
        exp_t e; int n; int prev;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) data_in[i*8 +: 8] = 8'h10 + 8'(i);
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{g:4'b0001 << (k % 4), d:8'h10 + 8'(k % 4), o:2'(k % 4)});
        end
        req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            e = sb.pop_front();
            wait_load(n);
            checks++;
            if (grant !== e.g || (k > 0 && cyc - prev != 4) || (k == 0 && n != 1)) begin
                failures++;
                $display("FAIL all_grant[%0d]: grant=%b gap=%0d, expected %b gap=4", k, grant, cyc - prev, e.g);
            end
            prev = cyc;
            @(negedge clk);
            checks++;
            if (Q !== e.d || owner !== e.o || valid !== 1'b1) begin
                failures++;
                $display("FAIL all_load[%0d]: Q=%h owner=%0d, expected Q=%h owner=%0d", k, Q, owner, e.d, e.o);
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_withdraw();
        exp_t e; int n;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        data_in = '0; data_in[23:16] = 8'h5A; data_in[7:0] = 8'h11;
        sb.push_back('{g:4'b0100, d:8'h5A, o:2'd2});
        sb.push_back('{g:4'b0001, d:8'h11, o:2'd0});
        req = 4'b0100;
        e = sb.pop_front();
        wait_load(n);
        @(negedge clk);
        checks++;
        if (Q !== e.d || owner !== e.o) begin
            failures++;
            $display("FAIL withdraw_setup: Q=%h owner=%0d, expected Q=%h owner=%0d", Q, owner, e.d, e.o);
        end
        req = '0;
        repeat (3) @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL withdraw_grant: grant=%b, expected 0001", grant);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (Q !== e.d || owner !== e.o || valid !== 1'b1 || grant !== 4'b0) begin
            failures++;
            $display("FAIL withdraw_nocapture: Q=%h owner=%0d grant=%b, expected Q=%h owner=%0d grant=0000",
                     Q, owner, grant, e.d, e.o);
        end
        // pointer still at 3, so 0 wins over 1; IDLE now so grant comes next cycle
        req = 4'b0011;
        e = sb.pop_front();
        @(negedge clk);
        checks++;
        if (grant !== e.g) begin
            failures++;
            $display("FAIL withdraw_regrant: grant=%b, expected %b", grant, e.g);
        end
        @(negedge clk);
        checks++;
        if (Q !== e.d || owner !== e.o) begin
            failures++;
            $display("FAIL withdraw_reload: Q=%h owner=%0d, expected Q=%h owner=%0d", Q, owner, e.d, e.o);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_hold();
        exp_t e; int n;
        data_in[15:8] = 8'h3C; data_in[31:24] = 8'hC3;
        sb.push_back('{g:4'b0010, d:8'h3C, o:2'd1});
        sb.push_back('{g:4'b1000, d:8'hC3, o:2'd3});
        e = sb.pop_front();
        req = 4'b0010;
        wait_load(n);
        checks++;
        if (grant !== e.g || n != 1) begin
            failures++;
            $display("FAIL hold_first_grant: grant=%b after %0d, expected %b after 1", grant, n, e.g);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req = 4'b1000;
            checks++;
            if (grant !== 4'b0 || Q !== 8'h3C || owner !== 2'd1) begin
                failures++;
                $display("FAIL hold_stable[%0d]: grant=%b Q=%h owner=%0d, expected grant=0000 Q=3c owner=1",
                         k, grant, Q, owner);
            end
        end
        e = sb.pop_front();
        @(negedge clk);
        checks++;
        if (grant !== e.g) begin
            failures++;
            $display("FAIL hold_after_grant: grant=%b, expected %b", grant, e.g);
        end
        @(negedge clk);
        checks++;
        if (Q !== e.d || owner !== e.o) begin
            failures++;
            $display("FAIL hold_after_load: Q=%h owner=%0d, expected Q=%h owner=%0d", Q, owner, e.d, e.o);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e; int n;
        data_in[15:8] = 8'h77; data_in[7:0] = 8'h01;
        sb.push_back('{g:4'b0001, d:8'h01, o:2'd0});
        req = 4'b0010;
        wait_load(n);
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL midreset_setup: grant=%b, expected 0010", grant);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (Q !== 8'h00 || valid !== 1'b0 || grant !== 4'b0 || owner !== 2'd0) begin
            failures++;
            $display("FAIL midreset_clear: Q=%h valid=%b grant=%b owner=%0d, expected all zero",
                     Q, valid, grant, owner);
        end
        reset = 1'b0;
        req = 4'b0011;
        e = sb.pop_front();
        wait_load(n);
        checks++;
        if (grant !== e.g || n != 1) begin
            failures++;
            $display("FAIL midreset_grant: grant=%b after %0d, expected %b after 1", grant, n, e.g);
        end
        @(negedge clk);
        checks++;
        if (Q !== e.d || owner !== e.o || valid !== 1'b1) begin
            failures++;
            $display("FAIL midreset_load: Q=%h owner=%0d valid=%b, expected Q=%h owner=%0d valid=1",
                     Q, owner, valid, e.d, e.o);
        end
        req = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_request();
        test_withdraw();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
